alu_seq_multiplier: RTL and testbench



---
 rtl/alu_mul_pkg.sv | 27 ++
 rtl/alu_seq_multiplier.sv | 117 +++++++++++
 tb/tb_alu_seq_multiplier.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/alu_mul_pkg.sv
// Shared types and helpers for the ALU sequential multiplier.
// The negation helper works at the widest product size; callers cast to their own width.
package alu_mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      SIGN = 2'd2
   } mul_state_e;

   localparam int MUL_WIDTH_DEFAULT = 8;
   localparam int MUL_MAX_PROD      = 64;

   function automatic logic [MUL_MAX_PROD-1:0] cond_negate(
      input logic [MUL_MAX_PROD-1:0] value,
      input logic                    negate
   );
      logic [MUL_MAX_PROD-1:0] res;
      if (negate) begin
         res = ~value + 64'd1;
      end else begin
         res = value;
      end
      return res;
   endfunction

endpackage

// File: rtl/alu_seq_multiplier.sv
// WIDTH x WIDTH radix-2 shift-add multiplier with signed/unsigned mode.
// Operands are reduced to magnitudes at capture; the sign is applied once in SIGN.
module alu_seq_multiplier
   import alu_mul_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 signed_mode,
   input  logic [WIDTH-1:0]     first,
   input  logic [WIDTH-1:0]     second,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   result
);

   localparam int CW = $clog2(WIDTH + 1);

   mul_state_e         state_r, state_next_s;
   logic [WIDTH-1:0]   mcand_r, mcand_next_s;
   logic [WIDTH-1:0]   mplier_r, mplier_next_s;
   logic [2*WIDTH:0]   acc_r, acc_next_s;
   logic [CW-1:0]      count_r, count_next_s;
   logic               neg_r, neg_next_s;
   logic               busy_r, busy_next_s;
   logic               done_r, done_next_s;
   logic [2*WIDTH-1:0] result_r, result_next_s;
   logic [WIDTH:0]     addend_s;
   logic [WIDTH:0]     sum_s;

   assign busy   = busy_r;
   assign done   = done_r;
   assign result = result_r;

   // Next-state and datapath updates for the IDLE/RUN/SIGN sequence
   always_comb begin
      state_next_s  = state_r;
      mcand_next_s  = mcand_r;
      mplier_next_s = mplier_r;
      acc_next_s    = acc_r;
      count_next_s  = count_r;
      neg_next_s    = neg_r;
      done_next_s   = 1'b0;
      result_next_s = result_r;

      if (mplier_r[0]) begin
         addend_s = {1'b0, mcand_r};
      end else begin
         addend_s = '0;
      end
      // acc_r[2*WIDTH] is always zero here; the add carry lands in it before the shift
      sum_s = acc_r[2*WIDTH:WIDTH] + addend_s;

      case (state_r)
         IDLE: begin
            if (start) begin
               state_next_s  = RUN;
               mcand_next_s  = WIDTH'(cond_negate(64'(first),  signed_mode & first[WIDTH-1]));
               mplier_next_s = WIDTH'(cond_negate(64'(second), signed_mode & second[WIDTH-1]));
               acc_next_s    = '0;
               count_next_s  = CW'(WIDTH);
               neg_next_s    = signed_mode & (first[WIDTH-1] ^ second[WIDTH-1]);
            end else begin
               state_next_s  = IDLE;
            end
         end
         RUN: begin
            acc_next_s    = {1'b0, sum_s, acc_r[WIDTH-1:1]};
            mplier_next_s = mplier_r >> 1;
            count_next_s  = count_r - CW'(1);
            if (count_r == CW'(1)) begin
               state_next_s = SIGN;
            end else begin
               state_next_s = RUN;
            end
         end
         SIGN: begin
            result_next_s = (2*WIDTH)'(cond_negate(64'(acc_r[2*WIDTH-1:0]), neg_r));
            done_next_s   = 1'b1;
            state_next_s  = IDLE;
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase

      busy_next_s = (state_next_s != IDLE);
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         mcand_r  <= '0;
         mplier_r <= '0;
         acc_r    <= '0;
         count_r  <= '0;
         neg_r    <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         result_r <= '0;
      end else begin
         state_r  <= state_next_s;
         mcand_r  <= mcand_next_s;
         mplier_r <= mplier_next_s;
         acc_r    <= acc_next_s;
         count_r  <= count_next_s;
         neg_r    <= neg_next_s;
         busy_r   <= busy_next_s;
         done_r   <= done_next_s;
         result_r <= result_next_s;
      end
   end

endmodule

// File: tb/tb_alu_seq_multiplier.sv
// Directed bench for alu_seq_multiplier at WIDTH=8 and WIDTH=16.
module tb_alu_seq_multiplier;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        start8 = 1'b0, sm8 = 1'b0;
   logic [7:0]  a8 = 8'd0, b8 = 8'd0;
   logic        busy8, done8;
   logic [15:0] res8;

   logic        start16 = 1'b0, sm16 = 1'b0;
   logic [15:0] a16 = 16'd0, b16 = 16'd0;
   logic        busy16, done16;
   logic [31:0] res16;

   int n_vec  = 0;
   int n_miss = 0;
   int overlap = 0;

   always #5 clk = ~clk;

   alu_seq_multiplier #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
      .first(a8), .second(b8), .busy(busy8), .done(done8), .result(res8)
   );

   alu_seq_multiplier #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(sm16),
      .first(a16), .second(b16), .busy(busy16), .done(done16), .result(res16)
   );

   always @(negedge clk) begin
      if ((busy8 && done8) || (busy16 && done16)) overlap++;
   end

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic        sm;
      logic [15:0] exp;
   } vec8_t;

   vec8_t vecs[14];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Launch one WIDTH=8 op; if now is set, start is raised in the current cycle.
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                      input logic [15:0] exp, input string nm, input bit now);
      int edges;
      if (!now) @(negedge clk);
      a8 = a; b8 = b; sm8 = sm; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      check({nm, " busy"}, {31'd0, busy8}, 32'd1);
      edges = 0;
      while (!done8 && edges < 20) begin
         @(posedge clk); #1;
         edges++;
      end
      check({nm, " latency"}, edges, 32'd9);
      check({nm, " result"}, {16'd0, res8}, {16'd0, exp});
   endtask

   task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic sm,
                       input logic [31:0] exp, input string nm);
      int edges;
      @(negedge clk);
      a16 = a; b16 = b; sm16 = sm; start16 = 1'b1;
      @(posedge clk); #1;
      start16 = 1'b0;
      edges = 0;
      while (!done16 && edges < 40) begin
         @(posedge clk); #1;
         edges++;
      end
      check({nm, " latency"}, edges, 32'd17);
      check({nm, " result"}, res16, exp);
   endtask

   initial begin
      int edges;
      int dones;

      vecs[0]  = '{8'h80, 8'h01, 1'b0, 16'h0080};
      vecs[1]  = '{8'h80, 8'h01, 1'b1, 16'hFF80};
      vecs[2]  = '{8'h40, 8'h80, 1'b0, 16'h2000};
      vecs[3]  = '{8'h40, 8'h80, 1'b1, 16'hE000};
      vecs[4]  = '{8'h80, 8'h80, 1'b0, 16'h4000};
      vecs[5]  = '{8'h80, 8'h80, 1'b1, 16'h4000};
      vecs[6]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
      vecs[7]  = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
      vecs[8]  = '{8'h7F, 8'h81, 1'b0, 16'h3FFF};
      vecs[9]  = '{8'h7F, 8'h81, 1'b1, 16'hC0FF};
      vecs[10] = '{8'h05, 8'hFD, 1'b1, 16'hFFF1};
      vecs[11] = '{8'h00, 8'hFF, 1'b1, 16'h0000};
      vecs[12] = '{8'hFD, 8'h05, 1'b0, 16'h04F1};
      vecs[13] = '{8'h0C, 8'h0B, 1'b1, 16'h0084};

      repeat (2) @(posedge clk);
      #1;
      check("reset busy",   {31'd0, busy8}, 32'd0);
      check("reset done",   {31'd0, done8}, 32'd0);
      check("reset result", {16'd0, res8},  32'd0);
      check("reset result16", res16, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 14; i++) begin
         op8(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].exp, $sformatf("vec%0d", i), 1'b0);
      end

      // result holds and done is a single pulse
      @(posedge clk); #1;
      check("done pulse width", {31'd0, done8}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("result hold", {16'd0, res8}, 32'h0084);

      // start while busy is ignored
      @(negedge clk);
      a8 = 8'h03; b8 = 8'h05; sm8 = 1'b0; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      a8 = 8'hFF; b8 = 8'hFF; sm8 = 1'b1; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      edges = 4;
      while (!done8 && edges < 20) begin
         @(posedge clk); #1;
         edges++;
      end
      check("ignored start latency", edges, 32'd9);
      check("ignored start result", {16'd0, res8}, 32'h000F);
      repeat (12) @(posedge clk);
      #1;
      check("no second done", {31'd0, busy8 | done8}, 32'd0);

      // reset mid-RUN aborts without a done pulse
      @(negedge clk);
      a8 = 8'h11; b8 = 8'h11; sm8 = 1'b0; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("abort busy",   {31'd0, busy8}, 32'd0);
      check("abort result", {16'd0, res8},  32'd0);
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         if (done8) dones++;
         @(posedge clk); #1;
      end
      check("abort no done", dones, 32'd0);
      op8(8'h11, 8'h11, 1'b0, 16'h0121, "after abort", 1'b0);

      // back-to-back: second start raised in the done cycle
      op8(8'h12, 8'h34, 1'b0, 16'h03A8, "b2b first", 1'b0);
      op8(8'hFE, 8'h03, 1'b1, 16'hFFFA, "b2b second", 1'b1);

      op16(16'h8000, 16'h8000, 1'b1, 32'h40000000, "w16 min*min");
      op16(16'hFFFF, 16'h0002, 1'b1, 32'hFFFFFFFE, "w16 -1*2");
      op16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "w16 max*max");

      check("busy/done overlap", overlap, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
